// File: rtl/dcm_pll_ctrl_pkg.sv
// dcm_pll_ctrl_pkg
//   Shared definitions for the dcm_pll reset/lock sequencer.
//   - state_t   : sequencer state encoding (also exported on dbg_state)
//   - cnt_width : bits needed to hold a counter's terminal value (minimum 1)
package dcm_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/dcm_pll_ctrl_sync.sv
// dcm_pll_ctrl_sync
//   Two-flop synchroniser that brings the asynchronous PLL/DCM lock
//   indication into the reference clock domain. Fixed 2-cycle latency.
// Ports:
//   clk        in   reference clock
//   rst_n      in   synchronous active-low reset (clears both flops to 0)
//   pll_locked in   raw lock indication, asynchronous to clk
//   locked_s   out  synchronised lock
module dcm_pll_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic locked_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      meta     <= pll_locked;
      locked_s <= meta;
    end
  end

endmodule

// File: rtl/dcm_pll_ctrl.sv
// dcm_pll_ctrl
//   Reset and lock sequencer for the dcm_pll clock generator feeding the
//   memory controller. Pulses the PLL/DCM reset, waits for a stable lock
//   (with timeout and bounded retries), holds the memory-controller domain
//   in reset for a release delay, then runs. Lock loss re-sequences; retry
//   exhaustion parks in FAILED until restart or rst_n.
//
// Optional build macro: DCM_PLL_CTRL_LOSS_FILTER_EN
//   When defined, lock loss in RUN is only declared after LOSS_FILTER
//   consecutive cycles of locked_s=0. When undefined, one cycle suffices.
//
// Ports:
//   clk         in   free-running reference clock
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   PLL/DCM lock (asynchronous, synchronised internally)
//   restart     in   one-cycle request to re-sequence from scratch
//   pll_rst     out  active-high PLL/DCM reset
//   dom_rst     out  active-high memory-controller domain reset
//   ready       out  high only in RUN
//   failed      out  high only in FAILED
//   retry_cnt   out  timeout retries used in the current sequence
//   dbg_state   out  current sequencer state
//
// Interface note: there is no valid/ready handshake here. restart is a
// level sampled on every clock edge; any cycle it is high forces PLL_RST.
module dcm_pll_ctrl
  import dcm_pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int LOCK_STABLE    = 64,
  parameter int RELEASE_DLY    = 16,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16,
  parameter int LOSS_FILTER    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           restart,
  output logic                           pll_rst,
  output logic                           dom_rst,
  output logic                           ready,
  output logic                           failed,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output state_t                         dbg_state
);

  localparam int     RW      = $clog2(MAX_RETRY + 1);
  localparam int     SW      = cnt_width(LOCK_STABLE);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);

  // Reject parameter sets the counters cannot represent.
  if (CNT_W < 1 || CNT_W > 31 ||
      PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 ||
      RELEASE_DLY < 1 || MAX_RETRY < 1 || LOSS_FILTER < 1 ||
      longint'(PLL_RST_CYCLES) > CNT_MAX || longint'(LOCK_TIMEOUT) > CNT_MAX ||
      longint'(RELEASE_DLY) > CNT_MAX || longint'(LOCK_STABLE) > CNT_MAX ||
      longint'(LOSS_FILTER) > CNT_MAX) begin : g_param_error
    $error("dcm_pll_ctrl: parameter value out of range for CNT_W");
  end

  logic locked_s;

  dcm_pll_ctrl_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .locked_s   (locked_s)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;     // shared: reset pulse / timeout / release
  logic [SW-1:0]     scnt_q, scnt_d, scnt_inc;  // consecutive locked_s cycles
  logic [RW-1:0]     retry_q, retry_d;
  logic              lock_lost;

  // Saturating increments: counters never wrap.
  assign cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q  + CNT_W'(1);
  assign scnt_inc = (&scnt_q) ? scnt_q : scnt_q + SW'(1);

`ifdef DCM_PLL_CTRL_LOSS_FILTER_EN
  localparam int LW = cnt_width(LOSS_FILTER);

  logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;

  assign lcnt_inc  = (&lcnt_q) ? lcnt_q : lcnt_q + LW'(1);
  assign lock_lost = !locked_s && (lcnt_inc >= LW'(LOSS_FILTER));

  // Counts consecutive low cycles only while staying in RUN; any return
  // of locked_s or any state change clears it.
  always_comb begin
    lcnt_d = '0;
    if (state_q == RUN && state_d == RUN && !locked_s) lcnt_d = lcnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lcnt_q <= '0;
    else        lcnt_q <= lcnt_d;
  end
`else
  assign lock_lost = !locked_s;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_inc >= CNT_W'(PLL_RST_CYCLES)) state_d = WAIT_LOCK;
        else                                   cnt_d   = cnt_inc;
      end

      WAIT_LOCK: begin
        cnt_d  = cnt_inc;
        scnt_d = locked_s ? scnt_inc : '0;
        // Stable lock is checked first so it wins over a coincident timeout.
        if (locked_s && scnt_inc >= SW'(LOCK_STABLE)) begin
          state_d = RELEASE;
        end else if (cnt_inc >= CNT_W'(LOCK_TIMEOUT)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = PLL_RST;
          end else begin
            state_d = FAILED;
          end
        end
      end

      RELEASE: begin
        if (!locked_s) begin
          state_d = PLL_RST;
        end else if (cnt_inc >= CNT_W'(RELEASE_DLY)) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RUN: begin
        if (lock_lost) state_d = PLL_RST;
      end

      FAILED: begin
        state_d = FAILED;
      end

      default: begin
        state_d = PLL_RST;
      end
    endcase

    // Every state entry starts its counters from zero.
    if (state_d != state_q) begin
      cnt_d  = '0;
      scnt_d = '0;
    end

    if (restart) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      scnt_d  = '0;
      retry_d = '0;
    end
  end

  // State and registered, state-decoded outputs. Outputs are decoded from
  // state_d so they line up with state_q on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      scnt_q  <= '0;
      retry_q <= '0;
      pll_rst <= 1'b1;
      dom_rst <= 1'b1;
      ready   <= 1'b0;
      failed  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      retry_q <= retry_d;
      pll_rst <= (state_d == PLL_RST) || (state_d == FAILED);
      dom_rst <= (state_d != RUN);
      ready   <= (state_d == RUN);
      failed  <= (state_d == FAILED);
    end
  end

  assign retry_cnt = retry_q;
  assign dbg_state = state_q;

endmodule
